serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder controller that sequences one 1-bit full adder cell `adder` over WIDTH-bit operands.
//  - Uses one `adder` instance, one bit per clock, LSB first.
//  - Owns the operand shift registers, the carry flop, the bit counter and the start/done handshake.
//  - Sits in the ALU as the area-minimal add path; the ALU top issues start and collects sum/flags.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 1..32
// PORTS
//  clk       in   1      clock; all state updates on the rising edge
//  rst       in   1      reset, synchronous, active-high
//  start     in   1      request; sampled only in IDLE or DONE
//  a         in   WIDTH  operand A; captured on an accepted start
//  b         in   WIDTH  operand B; captured on an accepted start
//  sub       in   1      1 = A-B; present only with SERIAL_SUB_EN; captured on an accepted start
//  busy      out  1      high in RUN
//  done      out  1      one-cycle pulse; high in DONE
//  sum       out  WIDTH  result; valid from done onward, held until the next accepted start
//  cout      out  1      carry out of the MSB; held like sum
//  overflow  out  1      signed overflow = carry into MSB ^ carry out of MSB; held like sum
// BEHAVIOUR
//  - Reset: state = IDLE; busy, done, sum, cout and overflow = 0; shift regs, carry flop and counter = 0.
//    Reset wins over every other event, including a run in progress: the run aborts, no done pulse.
//  - FSM states and transitions:
//    - IDLE: start=1 -> RUN (accepted start).
//    - RUN: WIDTH cycles, then -> DONE.
//    - DONE: one cycle. start=1 -> RUN (back-to-back accepted start); else -> IDLE.
//  - Accepted start:
//    - ra <= a, rb <= b.
//    - carry flop <= 0 (or <= sub under SERIAL_SUB_EN).
//    - cnt <= 0.
//    - sum, cout and overflow clear to 0.
//  - Each RUN cycle:
//    - The cell adds ra[0], rb[0] (or ~rb[0] when subtracting) and the carry flop.
//    - ra and rb shift right by 1.
//    - The sum bit shifts into rs at the MSB (rs shifts right), so after WIDTH cycles rs holds the result.
//    - carry flop <= cell cout; cnt++.
//  - Last RUN cycle (cnt == WIDTH-1):
//    - Capture overflow = carry flop (the carry into the MSB) ^ cell cout.
//    - Capture cout = cell cout; sum <= final rs value.
//    - -> DONE.
//  - Latency: start sampled at edge k -> busy high for edges k+1..k+WIDTH -> done high for the cycle
//    after edge k+WIDTH. Back-to-back throughput is one result per WIDTH+1 cycles.
//  - start while in RUN is ignored; the operands of the running job are unaffected by changes on a/b.
//  - a and b are don't-care except on the accepting edge.
//  - WIDTH=1: exactly one RUN cycle; overflow = cin ^ cout of that single bit.
//  - Arithmetic is modulo 2^WIDTH; cout is the unsigned carry (for subtract, cout=1 means no borrow).
// CONFIGURATION
//  SERIAL_SUB_EN defined:
//    - `sub` port exists.
//    - A subtract run inverts each rb bit into the cell and seeds the carry flop with 1 (two's complement A-B).
//  SERIAL_SUB_EN undefined:
//    - No `sub` port; add only.
//    - Carry seed is always 0 and rb is used uninverted.
// TESTING (WIDTH=8)
//  - a=0x35, b=0x4A, start -> done at k+9; sum=0x7F, cout=0, overflow=0; busy high for exactly 8 cycles.
//  - a=0xFF, b=0x01 -> sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, overflow=1.
//  - Two operations back-to-back: start held high through DONE with a=0x01, b=0x02 -> second done 9 cycles
//    after the first; sum=0x03.
//  - Pulse start again mid-RUN with different a/b -> ignored; the original result is returned at the original time.
//  - Assert rst at RUN cycle 4 -> the next cycle shows IDLE with busy, done, sum and cout all 0, and no done pulse follows.
//  - SERIAL_SUB_EN, sub=1: a=0x10, b=0x01 -> sum=0x0F, cout=1; a=0x80, b=0x01 -> sum=0x7F, overflow=1.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: start/operand/result bundle between the ALU top and the serial adder (sub only with SERIAL_SUB_EN)
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a, b;
`ifdef SERIAL_SUB_EN
  logic sub;
`endif
  logic busy, done;
  logic [WIDTH-1:0] sum;
  logic cout, overflow;
  modport master (
`ifdef SERIAL_SUB_EN
    output sub,
`endif
    output start, a, b,
    input busy, done, sum, cout, overflow
  );
  modport slave (
`ifdef SERIAL_SUB_EN
    input sub,
`endif
    input start, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder sequencing one full-adder cell LSB first; SERIAL_SUB_EN adds A-B
module adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  serial_add_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state, state_nx;
  logic [WIDTH-1:0] ra, rb, rs, rs_nx, sum_q;
  logic [CW-1:0] cnt;
  logic c, cout_q, ov_q, bin, seed, s, co, accept, last;
  assign accept = bus.start && (state == IDLE || state == DONE);
  assign last = cnt == CW'(WIDTH - 1);
`ifdef SERIAL_SUB_EN
  logic rsub;
  assign bin  = rb[0] ^ rsub;
  assign seed = bus.sub;
`else
  assign bin  = rb[0];
  assign seed = 1'b0;
`endif
  adder u_adder (.x(ra[0]), .y(bin), .ci(c), .s(s), .co(co));
  always_comb begin
    rs_nx = rs >> 1;
    rs_nx[WIDTH-1] = s;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = accept ? RUN : (state == RUN && last) ? DONE : (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ra <= '0;
      rb <= '0;
      rs <= '0;
      c <= 1'b0;
      cnt <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ov_q <= 1'b0;
`ifdef SERIAL_SUB_EN
      rsub <= 1'b0;
`endif
    end else if (accept) begin
      ra <= bus.a;
      rb <= bus.b;
      rs <= '0;
      c <= seed;
      cnt <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ov_q <= 1'b0;
`ifdef SERIAL_SUB_EN
      rsub <= bus.sub;
`endif
    end else if (state == RUN) begin
      ra <= ra >> 1;
      rb <= rb >> 1;
      rs <= rs_nx;
      c <= co;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum_q <= rs_nx;
        cout_q <= co;
        // c still holds the carry into the MSB here
        ov_q <= c ^ co;
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.overflow = ov_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed table vectors plus back-to-back, mid-run start and mid-run reset sequences
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  serial_add_ctrl_if #(.WIDTH(W)) bus ();
  serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [W-1:0] a, b;
    logic sb;
    logic [W-1:0] s;
    logic co, ov;
  } vec_t;
  vec_t v[7];
  int checks = 0;
  int failures = 0;
  time t_done = 0;
  time t_prev = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb,
                        input logic [W-1:0] es, input logic eco, input logic eov, input int poke);
    int busy_n = 0;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
`ifdef SERIAL_SUB_EN
    bus.sub = sb;
`else
    if (sb) $display("sub vector skipped in add-only build");
`endif
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    chk("sum_cleared_on_start", {24'd0, bus.sum}, 32'd0);
    for (int i = 0; i < W; i++) begin
      if (bus.busy && !bus.done) busy_n++;
      @(negedge clk);
      if (i == poke) begin
        bus.start = 1'b1;
        bus.a = 8'hAA;
        bus.b = 8'h55;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    chk("busy_cycles", busy_n, W);
    chk("done_at_k+W+1", {31'd0, bus.done}, 32'd1);
    chk("busy_low_in_done", {31'd0, bus.busy}, 32'd0);
    chk("sum", {24'd0, bus.sum}, {24'd0, es});
    chk("cout", {31'd0, bus.cout}, {31'd0, eco});
    chk("overflow", {31'd0, bus.overflow}, {31'd0, eov});
    t_prev = t_done;
    t_done = $time;
  endtask
  initial begin
    logic seen;
    v[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    v[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    v[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    v[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    v[4] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
    v[5] = '{8'hC0, 8'h40, 1'b0, 8'h00, 1'b1, 1'b0};
    v[6] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef SERIAL_SUB_EN
    bus.sub = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sum", {24'd0, bus.sum}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // each op starts during the previous DONE cycle, so these run back-to-back
    for (int i = 0; i < 7; i++) begin
      run_op(v[i].a, v[i].b, v[i].sb, v[i].s, v[i].co, v[i].ov, -1);
      if (i > 0) chk("back_to_back_interval", 32'(t_done - t_prev), 32'd90);
    end
    @(posedge clk);
    #1;
    chk("done_pulse_one_cycle", {31'd0, bus.done}, 32'd0);
    chk("idle_not_busy", {31'd0, bus.busy}, 32'd0);
    chk("sum_held", {24'd0, bus.sum}, 32'h03);
    run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.a = 8'hFF;
    bus.b = 8'h01;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_sum", {24'd0, bus.sum}, 32'd0);
    chk("abort_cout", {31'd0, bus.cout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      seen |= bus.done | bus.busy;
    end
    chk("no_done_after_abort", {31'd0, seen}, 32'd0);
`ifdef SERIAL_SUB_EN
    run_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0, -1);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, -1);
    run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, -1);
    run_op(8'h05, 8'h07, 1'b0, 8'h0C, 1'b0, 1'b0, -1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
